gate_truth_checker: RTL and testbench
=====================================

// Module: gate_truth_checker
// PURPOSE
// Sequential stimulus/response unit that closes the loop on any 2-input combinational gate.
// Drives all four input combinations (a,b) = 00,01,10,11 into the gate under test.
// Samples the gate output after a programmable settle time and compares the 4-entry truth table against EXPECT_TT.
// Sits at the lab top level beside the gate models so a pass/fail result is available in hardware without a testbench.
// PARAMETERS
// EXPECT_TT   4'b0001  expected truth table; bit i = expected out for {a,b}=i (0001 = NOR)
// SETTLE_CYC  2        clock cycles each vector is held before sampling; legal range 1..15
// PORTS
// clk         in   1  rising-edge clock
// rst_n       in   1  asynchronous active-low reset
// start       in   1  1-cycle request to run a full check; ignored while busy=1
// abort       in   1  synchronous cancel of a running check
// dut_out     in   1  output of gate under test
// dut_a       out  1  gate input a (registered)
// dut_b       out  1  gate input b (registered)
// busy        out  1  high from the edge after start until the final sample edge
// done        out  1  1-cycle pulse when a check completes (not on abort)
// pass        out  1  captured_tt == EXPECT_TT; valid from done, held until next accepted start
// fail_mask   out  4  captured_tt ^ EXPECT_TT; valid/held like pass
// captured_tt out  4  sampled outputs; bit i = dut_out for vector i
// BEHAVIOUR
// - Reset: state IDLE.
//   - All outputs 0: dut_a, dut_b, busy, done, pass, fail_mask, captured_tt.
//   - idx = 0, settle counter = 0.
//   - Reset asserted mid-check abandons it with no done pulse.
// - States:
//   - IDLE:   start=1 -> SETTLE.
//     - idx<=0, cnt<=0, busy<=1, {dut_a,dut_b}<=2'b00.
//     - captured_tt, pass, fail_mask <= 0.
//   - SETTLE: cnt increments each cycle; when cnt==SETTLE_CYC-1 -> SAMPLE.
//   - SAMPLE: captured_tt[idx] <= dut_out.
//     - If idx!=3: idx<=idx+1, {dut_a,dut_b}<=idx+1, cnt<=0, -> SETTLE.
//     - If idx==3: -> IDLE, busy<=0, done<=1.
//       - pass <= ({dut_out,captured_tt[2:0]} == EXPECT_TT).
//       - fail_mask <= {dut_out,captured_tt[2:0]} ^ EXPECT_TT.
//       - Final bit is folded in the same edge; no extra cycle.
// - done is registered and auto-clears on the following edge.
// - Timing: vector k is driven from edge k*(SETTLE_CYC+1) and sampled at edge (k+1)*(SETTLE_CYC+1).
//   - Edge 0 is the one that accepts start.
//   - done is high for exactly the cycle following edge 4*(SETTLE_CYC+1); 12 cycles at default.
// - Back-to-back: start is not accepted while busy.
//   - start on the same edge as the final SAMPLE is ignored; busy is still 1 at that edge.
//   - start the cycle done is high is accepted normally.
// - abort:
//   - In SETTLE or SAMPLE it takes priority over sampling.
//   - Actions: -> IDLE, busy<=0, dut_a/dut_b<=0, no done.
//   - pass, fail_mask, captured_tt are left at their cleared-by-start values (0).
//   - In IDLE, abort has no effect.
//   - abort and start together in IDLE: start wins.
// - idx is 2 bits; it never wraps, because SAMPLE at idx==3 exits to IDLE.
// - cnt width is 4 bits; SETTLE_CYC outside 1..15 is illegal (flagged by a simulation-only check).
// - dut_out is sampled only in SAMPLE; glitches during SETTLE are invisible.
// TESTING
// - NOR gate on dut_out, defaults, start pulse -> dut_a/b step 00,01,10,11 every 3 cycles.
//   - done at cycle 12; captured_tt=0001, pass=1, fail_mask=0000.
// - dut_out tied to NAND of dut_a/dut_b -> captured_tt=0111, pass=0, fail_mask=0110.
// - Start NOR check, assert abort at cycle 5 -> busy=0 next cycle, dut_a=dut_b=0.
//   - No done for 20 cycles; pass=0, captured_tt=0000.
// - Pulse start again while busy at cycle 4 -> ignored; sequence and done timing unchanged (done at cycle 12).
// - Drop rst_n at cycle 7 of a check -> all outputs 0 immediately (async), without waiting for clk.
//   - After release, a new start gives a full clean run with pass=1.
// - SETTLE_CYC=1: done at cycle 8; start asserted in the done cycle -> second run accepted, done again at cycle 16.

Source files
------------

// File: rtl/gate_truth_checker_if.sv
// Handshake and gate-drive bundle between a truth-table checker and its controller/gate.
// The slave side is the checker; the master side issues start/abort and returns the gate output.
interface gate_truth_checker_if;
    logic       start;
    logic       abort;
    logic       dut_out;
    logic       dut_a;
    logic       dut_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [3:0] captured_tt;

    modport master (
        output start, abort, dut_out,
        input  dut_a, dut_b, busy, done, pass, fail_mask, captured_tt
    );

    modport slave (
        input  start, abort, dut_out,
        output dut_a, dut_b, busy, done, pass, fail_mask, captured_tt
    );
endinterface

// File: rtl/gate_truth_checker.sv
// Walks a 2-input gate through all four input vectors, samples each after a settle time
// and compares the captured truth table with EXPECT_TT.
//
// state  | meaning
// IDLE   | waiting for start; results held
// SETTLE | current vector driven, counting settle cycles
// SAMPLE | capture dut_out for current vector, advance or finish
module gate_truth_checker #(
    parameter logic [3:0] EXPECT_TT  = 4'b0001,
    parameter int         SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_truth_checker_if.slave  bus
);
    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] idx, idx_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [1:0] vec, vec_nxt;
    logic       busy, busy_nxt;
    logic       done, done_nxt;
    logic       pass, pass_nxt;
    logic [3:0] fail_mask, fail_mask_nxt;
    logic [3:0] captured_tt, captured_tt_nxt;
    logic [3:0] tt_final;

    a_settle_range: assert property (@(posedge clk) SETTLE_CYC inside {[1:15]});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= 2'd0;
            cnt         <= 4'd0;
            vec         <= 2'b00;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_mask   <= 4'd0;
            captured_tt <= 4'd0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            cnt         <= cnt_nxt;
            vec         <= vec_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            pass        <= pass_nxt;
            fail_mask   <= fail_mask_nxt;
            captured_tt <= captured_tt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        cnt_nxt         = cnt;
        vec_nxt         = vec;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        pass_nxt        = pass;
        fail_mask_nxt   = fail_mask;
        captured_tt_nxt = captured_tt;
        // Last sample is merged combinationally so the verdict lands on the same edge.
        tt_final        = {bus.dut_out, captured_tt[2:0]};

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt       = SETTLE;
                    idx_nxt         = 2'd0;
                    cnt_nxt         = 4'd0;
                    vec_nxt         = 2'b00;
                    busy_nxt        = 1'b1;
                    pass_nxt        = 1'b0;
                    fail_mask_nxt   = 4'd0;
                    captured_tt_nxt = 4'd0;
                end
            end
            SETTLE, SAMPLE: begin
                if (bus.abort) begin
                    // Partial captures are discarded so an aborted run reads as a clean slate.
                    state_nxt       = IDLE;
                    idx_nxt         = 2'd0;
                    cnt_nxt         = 4'd0;
                    vec_nxt         = 2'b00;
                    busy_nxt        = 1'b0;
                    pass_nxt        = 1'b0;
                    fail_mask_nxt   = 4'd0;
                    captured_tt_nxt = 4'd0;
                end else if (state == SETTLE) begin
                    cnt_nxt = cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = SAMPLE;
                    end
                end else begin
                    captured_tt_nxt[idx] = bus.dut_out;
                    if (idx != 2'd3) begin
                        idx_nxt   = idx + 2'd1;
                        vec_nxt   = idx + 2'd1;
                        cnt_nxt   = 4'd0;
                        state_nxt = SETTLE;
                    end else begin
                        state_nxt       = IDLE;
                        busy_nxt        = 1'b0;
                        done_nxt        = 1'b1;
                        captured_tt_nxt = tt_final;
                        pass_nxt        = (tt_final == EXPECT_TT);
                        fail_mask_nxt   = tt_final ^ EXPECT_TT;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.dut_a       = vec[1];
    assign bus.dut_b       = vec[0];
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.pass        = pass;
    assign bus.fail_mask   = fail_mask;
    assign bus.captured_tt = captured_tt;
endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (settle 2 and settle 1) driven by a programmable
// gate truth table with random glitches between sample points, checked against a timing model.
module tb_gate_truth_checker;
    localparam logic [3:0] EXP = 4'b0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gate_truth_checker_if if0 ();
    gate_truth_checker_if if1 ();

    gate_truth_checker #(.EXPECT_TT(EXP), .SETTLE_CYC(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    gate_truth_checker #(.EXPECT_TT(EXP), .SETTLE_CYC(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    logic       start_v = 1'b0;
    logic       abort_v = 1'b0;
    logic       glitch  = 1'b0;
    logic [3:0] gate_tt = 4'b0001;
    int         cur_sel = 0;

    assign if0.start   = start_v & (cur_sel == 0);
    assign if0.abort   = abort_v & (cur_sel == 0);
    assign if1.start   = start_v & (cur_sel == 1);
    assign if1.abort   = abort_v & (cur_sel == 1);
    assign if0.dut_out = gate_tt[{if0.dut_a, if0.dut_b}] ^ glitch;
    assign if1.dut_out = gate_tt[{if1.dut_a, if1.dut_b}] ^ glitch;

    logic       c_busy, c_done, c_pass;
    logic [1:0] c_ab;
    logic [3:0] c_fm, c_tt;
    always_comb begin
        c_busy = (cur_sel == 1) ? if1.busy        : if0.busy;
        c_done = (cur_sel == 1) ? if1.done        : if0.done;
        c_pass = (cur_sel == 1) ? if1.pass        : if0.pass;
        c_ab   = (cur_sel == 1) ? {if1.dut_a, if1.dut_b} : {if0.dut_a, if0.dut_b};
        c_fm   = (cur_sel == 1) ? if1.fail_mask   : if0.fail_mask;
        c_tt   = (cur_sel == 1) ? if1.captured_tt : if0.captured_tt;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
            $error("mismatch on %s", tag);
        end
    endtask

    task automatic chk_all(input string tag, input logic b, input logic d, input logic [1:0] ab,
                           input logic [3:0] tt, input logic p, input logic [3:0] fm);
        chk({tag, ".busy"}, 32'(c_busy), 32'(b));
        chk({tag, ".done"}, 32'(c_done), 32'(d));
        chk({tag, ".ab"},   32'(c_ab),   32'(ab));
        chk({tag, ".tt"},   32'(c_tt),   32'(tt));
        chk({tag, ".pass"}, 32'(c_pass), 32'(p));
        chk({tag, ".fm"},   32'(c_fm),   32'(fm));
    endtask

    // One check run. Cycle c counts edges after the accepting edge (edge 0).
    // abort_at/restart_at: edge index at which abort/start is presented (0 = never).
    task automatic run_check(input int sel, input int s, input logic [3:0] g,
                             input int abort_at, input int restart_at, input bit with_abort);
        int p, last, endc, n;
        logic [3:0] exp_tt;
        p    = s + 1;
        last = 4 * p;
        endc = (abort_at > 0) ? abort_at + 20 : last;
        cur_sel = sel;
        gate_tt = g;
        start_v = 1'b1;
        abort_v = with_abort;
        glitch  = 1'b0;
        for (int c = 0; c <= endc; c++) begin
            @(posedge clk); #1;
            start_v = (restart_at > 0) && (c + 1 == restart_at);
            abort_v = (abort_at > 0) && (c + 1 == abort_at);
            glitch  = (c + 1 < last && (c + 1) % p != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (abort_at > 0 && c >= abort_at) begin
                chk_all("abort", 1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0);
            end else if (c < last) begin
                n = c / p;
                exp_tt = g & 4'((1 << n) - 1);
                chk_all("run", 1'b1, 1'b0, 2'(n), exp_tt, 1'b0, 4'd0);
            end else begin
                chk_all("done", 1'b0, 1'b1, 2'b11, g, (g == EXP), g ^ EXP);
            end
        end
        start_v = 1'b0;
        abort_v = 1'b0;
        glitch  = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input logic [3:0] tt, input logic p, input logic [3:0] fm,
                               input logic [1:0] ab);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk_all("idle", 1'b0, 1'b0, ab, tt, p, fm);
        end
    endtask

    initial begin
        logic [3:0] g;
        int sel, s, ab_at, rs_at;

        #2;
        cur_sel = 0;
        chk_all("reset0", 1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0);
        cur_sel = 1;
        chk_all("reset1", 1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // NOR gate: clean pass.
        run_check(0, 2, 4'b0001, 0, 0, 1'b0);
        idle_cycles(2, 4'b0001, 1'b1, 4'b0000, 2'b11);

        // NAND gate: fail with mask 0110.
        run_check(0, 2, 4'b0111, 0, 0, 1'b0);
        idle_cycles(2, 4'b0111, 1'b0, 4'b0110, 2'b11);

        // abort in IDLE has no effect.
        abort_v = 1'b1;
        idle_cycles(2, 4'b0111, 1'b0, 4'b0110, 2'b11);
        abort_v = 1'b0;

        // abort at cycle 5, then 20 quiet cycles.
        run_check(0, 2, 4'b0001, 5, 0, 1'b0);

        // start while busy at cycle 4, and again on the final sample edge: both ignored.
        run_check(0, 2, 4'b0001, 0, 4, 1'b0);
        run_check(0, 2, 4'b0001, 0, 12, 1'b0);
        idle_cycles(2, 4'b0001, 1'b1, 4'b0000, 2'b11);

        // start together with abort in IDLE: start wins.
        run_check(0, 2, 4'b1001, 0, 0, 1'b1);
        idle_cycles(1, 4'b1001, 1'b0, 4'b1000, 2'b11);

        // asynchronous reset mid-check.
        cur_sel = 0;
        gate_tt = 4'b0001;
        start_v = 1'b1;
        @(posedge clk); #1;
        start_v = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_all("async_rst", 1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0);
        repeat (2) @(posedge clk);
        #1 chk_all("in_rst", 1'b0, 1'b0, 2'b00, 4'd0, 1'b0, 4'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_check(0, 2, 4'b0001, 0, 0, 1'b0);
        idle_cycles(1, 4'b0001, 1'b1, 4'b0000, 2'b11);

        // SETTLE_CYC=1: done at cycle 8, restart in the done cycle.
        run_check(1, 1, 4'b0001, 0, 0, 1'b0);
        run_check(1, 1, 4'b0001, 0, 0, 1'b0);
        idle_cycles(2, 4'b0001, 1'b1, 4'b0000, 2'b11);

        // Randomized runs on both instances.
        for (int r = 0; r < 16; r++) begin
            g     = 4'($urandom_range(0, 15));
            sel   = int'($urandom_range(0, 1));
            s     = (sel == 1) ? 1 : 2;
            ab_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4 * (s + 1))) : 0;
            rs_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4 * (s + 1))) : 0;
            if (ab_at > 0 && rs_at >= ab_at) rs_at = 0;
            run_check(sel, s, g, ab_at, rs_at, 1'($urandom_range(0, 1)));
            if (ab_at > 0) idle_cycles(1, 4'd0, 1'b0, 4'd0, 2'b00);
            else           idle_cycles(1, g, (g == EXP), g ^ EXP, 2'b11);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end
endmodule
